// File: rtl/timer_cnt_unit_pkg.sv
// timer_cnt_unit_pkg
//   Shared definitions for the 8-bit timer counting stage: clock-select
//   encodings, datapath widths and the counter extremes that the trigger
//   logic compares against to spot overflow and underflow.
package timer_cnt_unit_pkg;

  localparam int CNT_W = 8;
  localparam int DIV_W = 4;

  // cks encodings; the value is also the divider bit that drives clk_in.
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MIN = 8'h00;

endpackage

// File: rtl/timer_clk_div.sv
// timer_clk_div
//   Free-running 4-bit prescaler that produces the selected timer clock.
//   Ports:
//     pclk    in   system clock
//     presetn in   asynchronous active-low reset
//     en      in   timer enable; low clears the prescaler
//     cks     in   clock select (0..3 -> pclk/2 .. pclk/16)
//     clk_in  out  divided timer clock (mux of prescaler bits)
module timer_clk_div
  import timer_cnt_unit_pkg::*;
(
  input  logic       pclk,
  input  logic       presetn,
  input  logic       en,
  input  logic [1:0] cks,
  output logic       clk_in
);

  logic [DIV_W-1:0] div_cnt;

  // Clearing while disabled makes the first clk_in rise after enable land
  // exactly 2^cks cycles later, and forces clk_in low one edge after en
  // drops so no spurious edge reaches the trigger logic.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end else begin
      div_cnt <= '0;
    end
  end

  // Pure mux of flops: bit k toggles every 2^k cycles, period 2^(k+1).
  assign clk_in = div_cnt[cks];

endmodule

// File: rtl/timer_cnt_unit.sv
// timer_cnt_unit
//   Counting stage of the 8-bit timer: prescaler plus 8-bit up/down counter
//   with a one-cycle-delayed copy used by the trigger logic for wrap detect.
//   Ports:
//     pclk         in   system clock
//     presetn      in   asynchronous active-low reset
//     cks          in   clock select for clk_in
//     en           in   timer enable
//     ud           in   count direction (0 up, 1 down)
//     load         in   load tdr into cnt and last_cnt
//     tdr          in   load value
//     count_enable in   one-pclk strobe from the trigger edge detector
//     clk_in       out  divided timer clock
//     cnt          out  counter value
//     last_cnt     out  counter value one pclk earlier (tdr on load)
module timer_cnt_unit
  import timer_cnt_unit_pkg::*;
(
  input  logic             pclk,
  input  logic             presetn,
  input  logic [1:0]       cks,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [CNT_W-1:0] tdr,
  input  logic             count_enable,
  output logic             clk_in,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] last_cnt
);

  logic [CNT_W-1:0] cnt_next;

  timer_clk_div u_clk_div (
    .pclk    (pclk),
    .presetn (presetn),
    .en      (en),
    .cks     (cks),
    .clk_in  (clk_in)
  );

  // Modulo-256 step; ud is sampled only on the strobe itself.
  always_comb begin
    cnt_next = cnt;
    if (en && count_enable) begin
      cnt_next = ud ? (cnt - CNT_W'(1)) : (cnt + CNT_W'(1));
    end
  end

  // Load writes tdr into both registers so the pair can never read as
  // FF/00 or 00/FF across a load, i.e. a load cannot fake a wrap. Load also
  // overrides a coincident strobe, which is then lost.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt      <= CNT_MIN;
      last_cnt <= CNT_MIN;
    end else if (load) begin
      cnt      <= tdr;
      last_cnt <= tdr;
    end else begin
      cnt      <= cnt_next;
      last_cnt <= cnt;
    end
  end

endmodule

// File: tb/tb_timer_cnt_unit.sv
// tb_timer_cnt_unit
//   Self-checking bench for timer_cnt_unit. A small edge detector stands in
//   for the trigger logic and produces count_enable from clk_in. Expected
//   counter steps (value and pclk spacing) are queued when stimulus is
//   applied and compared when the counter changes.
module tb_timer_cnt_unit;
  import timer_cnt_unit_pkg::*;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic [1:0] cks = 2'd0;
  logic       en = 1'b0;
  logic       ud = 1'b0;
  logic       load = 1'b0;
  logic [7:0] tdr = 8'h00;
  logic       count_enable;
  logic       clk_in;
  logic [7:0] cnt;
  logic [7:0] last_cnt;

  always #5 pclk = ~pclk;

  timer_cnt_unit dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .cks          (cks),
    .en           (en),
    .ud           (ud),
    .load         (load),
    .tdr          (tdr),
    .count_enable (count_enable),
    .clk_in       (clk_in),
    .cnt          (cnt),
    .last_cnt     (last_cnt)
  );

  // Trigger-logic edge detector: strobe in the first cycle clk_in is high.
  logic clk_in_q;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) clk_in_q <= 1'b0;
    else          clk_in_q <= clk_in;
  end
  assign count_enable = clk_in & ~clk_in_q;

  typedef struct {
    string      tag;
    logic [7:0] val;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ovf_cnt = 0;
  int         udf_cnt = 0;
  int         gap = 0;
  logic       mon_en = 1'b0;
  logic [7:0] prev_cnt = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] val, input int g);
    exp_t e;
    e.tag = tag;
    e.val = val;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  // One pclk: let the edge happen, then sample on the falling edge. The
  // scoreboard pops one entry per observed counter change; gap counts the
  // edges since monitoring started or since the previous change.
  task automatic tick();
    exp_t e;
    @(posedge pclk);
    @(negedge pclk);
    if (last_cnt == CNT_MAX && cnt == CNT_MIN) ovf_cnt++;
    if (last_cnt == CNT_MIN && cnt == CNT_MAX) udf_cnt++;
    if (!mon_en) begin
      gap = 0;
    end else begin
      gap++;
      if (cnt !== prev_cnt) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {24'd0, cnt}, {24'd0, prev_cnt});
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_val"}, {24'd0, cnt}, {24'd0, e.val});
          check({e.tag, "_gap"}, gap, e.gap);
        end
        gap = 0;
      end
    end
    prev_cnt = cnt;
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("sb_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic load_value(input logic [7:0] v);
    tdr  = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int ovf0;
    int udf0;
    int n;
    logic p;
    logic rise;

    // Reset state
    @(negedge pclk);
    check("rst_cnt", {24'd0, cnt}, 32'h00);
    check("rst_last", {24'd0, last_cnt}, 32'h00);
    check("rst_clk_in", {31'd0, clk_in}, 32'd0);
    presetn = 1'b1;
    repeat (3) tick();
    check("post_rst_cnt", {24'd0, cnt}, 32'h00);

    // Up count with overflow, pclk/2
    cks = CKS_DIV2;
    ud  = 1'b0;
    load_value(8'hFD);
    check("up_load", {24'd0, cnt}, 32'hFD);
    check("up_load_last", {24'd0, last_cnt}, 32'hFD);
    ovf0 = ovf_cnt;
    udf0 = udf_cnt;
    push_exp("up_fe", 8'hFE, 2);
    push_exp("up_ff", 8'hFF, 2);
    push_exp("up_00", 8'h00, 2);
    en = 1'b1;
    mon_en = 1'b1;
    wait_sb(40);
    check("up_pair_last", {24'd0, last_cnt}, 32'hFF);
    en = 1'b0;
    mon_en = 1'b0;
    repeat (3) tick();
    check("up_ovf_once", ovf_cnt - ovf0, 1);
    check("up_no_udf", udf_cnt - udf0, 0);

    // Down count with underflow, pclk/16
    cks = CKS_DIV16;
    ud  = 1'b1;
    load_value(8'h02);
    check("dn_load", {24'd0, cnt}, 32'h02);
    ovf0 = ovf_cnt;
    udf0 = udf_cnt;
    push_exp("dn_01", 8'h01, 9);
    push_exp("dn_00", 8'h00, 16);
    push_exp("dn_ff", 8'hFF, 16);
    en = 1'b1;
    mon_en = 1'b1;
    wait_sb(100);
    check("dn_pair_last", {24'd0, last_cnt}, 32'h00);
    en = 1'b0;
    mon_en = 1'b0;
    repeat (3) tick();
    check("dn_udf_once", udf_cnt - udf0, 1);
    check("dn_no_ovf", ovf_cnt - ovf0, 0);

    // Load coincident with a strobe while cnt = FF
    cks = CKS_DIV2;
    ud  = 1'b0;
    load_value(8'hFE);
    ovf0 = ovf_cnt;
    en = 1'b1;
    repeat (3) tick();
    check("lvs_pre_cnt", {24'd0, cnt}, 32'hFF);
    check("lvs_pre_strobe", {31'd0, count_enable}, 32'd1);
    tdr  = 8'h00;
    load = 1'b1;
    tick();
    load = 1'b0;
    en   = 1'b0;
    check("lvs_cnt", {24'd0, cnt}, 32'h00);
    check("lvs_last", {24'd0, last_cnt}, 32'h00);
    repeat (3) tick();
    check("lvs_no_ovf", ovf_cnt - ovf0, 0);

    // Enable gating at cnt = 10, pclk/4
    cks = CKS_DIV4;
    ud  = 1'b0;
    load_value(8'h0F);
    en = 1'b1;
    n = 0;
    while (cnt != 8'h10 && n < 20) begin
      tick();
      n++;
    end
    check("gate_reach", {24'd0, cnt}, 32'h10);
    en = 1'b0;
    tick();
    check("gate_clk_low", {31'd0, clk_in}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("gate_hold_%0d", i), {23'd0, clk_in, cnt}, 32'h010);
    end
    push_exp("gate_11", 8'h11, 3);
    en = 1'b1;
    mon_en = 1'b1;
    tick();
    check("reen_clk_t1", {31'd0, clk_in}, 32'd0);
    tick();
    check("reen_clk_t2", {31'd0, clk_in}, 32'd1);
    check("reen_cnt_t2", {24'd0, cnt}, 32'h10);
    wait_sb(10);
    en = 1'b0;
    mon_en = 1'b0;

    // Clock-select sweep: first rise after enable and steady period
    for (int k = 0; k < 4; k++) begin
      en = 1'b0;
      repeat (2) tick();
      cks = 2'(k);
      en = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!clk_in && n < 40);
      check($sformatf("cks%0d_first_rise", k), n, 32'd1 << k);
      p = clk_in;
      n = 0;
      rise = 1'b0;
      while (!rise && n < 64) begin
        tick();
        n++;
        rise = clk_in && !p;
        p = clk_in;
      end
      check($sformatf("cks%0d_period", k), n, 32'd2 << k);
    end
    en = 1'b0;
    tick();

    // Asynchronous reset in the middle of counting at cnt = 5A
    cks = CKS_DIV2;
    ud  = 1'b0;
    load_value(8'h5A);
    en = 1'b1;
    tick();
    check("mid_pre_cnt", {24'd0, cnt}, 32'h5A);
    check("mid_pre_clk", {31'd0, clk_in}, 32'd1);
    presetn = 1'b0;
    #1;
    check("mid_rst_cnt", {24'd0, cnt}, 32'h00);
    check("mid_rst_last", {24'd0, last_cnt}, 32'h00);
    check("mid_rst_clk", {31'd0, clk_in}, 32'd0);
    en = 1'b0;
    repeat (2) tick();
    presetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("mid_idle_%0d", i), {15'd0, clk_in, last_cnt, cnt}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_cnt_unit.md
# timer_cnt_unit

Counting stage of the 8-bit timer, directly upstream of the trigger/edge-detect logic. It divides `pclk` into the selected timer clock `clk_in`, which goes to the trigger logic. It also holds the 8-bit up/down counter, which advances on the `count_enable` strobe returned from the trigger logic. It publishes `cnt` and a one-cycle-delayed `last_cnt`, and the trigger logic compares the two to detect overflow and underflow.

## Interface
- No parameters; width is fixed at 8 bits and the divider at 4 bits.
- `pclk`  in  1  system clock; the only clock.
- `presetn`  in  1  asynchronous, active-low reset.
- `cks`  in  2  clock select: 0 = pclk/2, 1 = pclk/4, 2 = pclk/8, 3 = pclk/16.
- `en`  in  1  timer enable.
- `ud`  in  1  direction: 0 = up, 1 = down.
- `load`  in  1  load `tdr` into the counter; may be a level or a pulse.
- `tdr`  in  8  load value.
- `count_enable`  in  1  one-pclk strobe from the trigger logic's edge detector.
- `clk_in`  out  1  divided timer clock.
- `cnt`  out  8  counter value.
- `last_cnt`  out  8  previous-cycle counter value; see the load rule below.

## Operation
- **Divider:** 4-bit register `div_cnt`.
  - When `en`=1, `div_cnt` increments every pclk and wraps 15 -> 0.
  - When `en`=0, `div_cnt` is cleared to 0.
  - `clk_in = div_cnt[cks]`, a mux of registered bits with no extra flop.
- **Counter update priority:**
  1. `load`=1: `cnt <= tdr`, regardless of `en`, `count_enable` or `ud`.
  2. `en`=1 and `count_enable`=1: `cnt <= cnt + 1` if `ud`=0, or `cnt - 1` if `ud`=1, modulo 256. So FF+1 = 00 and 00-1 = FF.
  3. Otherwise `cnt` holds.
- **last_cnt:**
  - `load`=1: `last_cnt <= tdr`.
  - Otherwise: `last_cnt <= cnt`.
  - Consequence: a load never leaves `last_cnt`/`cnt` at FF/00 or 00/FF, so a one-cycle load pulse cannot fake an overflow or underflow.
- **Wrap visibility:** after an FF->00 (up) or 00->FF (down) step, the pair (`last_cnt`, `cnt`) shows (FF, 00) or (00, FF) for exactly one pclk cycle.
- **Reset values:** `div_cnt` = 0, `clk_in` = 0, `cnt` = 00, `last_cnt` = 00. These apply immediately on `presetn` falling, including mid-count.
- **`en` falling:** freezes `cnt` and zeroes the divider.
  - `clk_in` drops on the next edge, so no spurious rising edge is produced.
  - On re-enable, the first `clk_in` rise is deterministic: 2^cks pclk cycles after `en` rises.
- **Changing `cks`:** software changes `cks` only while `en`=0. With `en`=1, a change may create or drop one `clk_in` edge; this is allowed, not a fault.
- **Direction:** `ud` is sampled on each count strobe. Changing it between strobes takes effect at the next strobe.

## Timing
- `count_enable` is asserted during the first pclk cycle in which `clk_in`=1.
- `cnt` updates at the end of that cycle: one count per 2^(cks+1) pclk.
- `last_cnt` lags `cnt` by exactly one pclk, except on load cycles.
- Load latency: 1 cycle. `cnt` = `tdr` on the edge after `load` is sampled high.
- Simultaneous `load` and `count_enable`: load wins and the count is lost.
- No handshakes and no pipeline stalls. All outputs are registered except `clk_in`, which is a mux of flops.

## Structure
- Shared timer package holds:
  - `cks` encodings: CKS_DIV2 = 0, CKS_DIV4 = 1, CKS_DIV8 = 2, CKS_DIV16 = 3.
  - Counter extremes: CNT_MAX = 8'hFF, CNT_MIN = 8'h00.
- One sub-module, `timer_clk_div`: the 4-bit divider plus the `cks` mux, with inputs `pclk`, `presetn`, `en`, `cks` and output `clk_in`.
- The counter and `last_cnt` registers live in the top. The bench instantiates the block together with the trigger logic so that `count_enable` is the real strobe.

## Test plan
- **Reset:** `presetn`=0 mid-count at `cnt`=5A -> `cnt`, `last_cnt` and `clk_in` are 0 in the same cycle; they stay 0 until `en`=1 after release.
- **Up count with overflow:**
  - Stimulus: `cks`=0, `ud`=0, load `tdr`=FD, then `en`=1.
  - Required: `cnt` steps FD, FE, FF, 00, one step every 2 pclk.
  - Required: (`last_cnt`, `cnt`) = (FF, 00) for exactly one cycle.
  - Required: the trigger logic sets `ovf_trig`.
- **Down count with underflow:**
  - Stimulus: `cks`=3, `ud`=1, load 02, `en`=1.
  - Required: steps 02, 01, 00, FF, spaced 16 pclk apart.
  - Required: (00, FF) shown once; `udf_trig` set.
- **Load versus strobe:**
  - Stimulus: `load` pulse with `tdr`=00 while `cnt`=FF, coincident with `count_enable`.
  - Required: `cnt`=00 and `last_cnt`=00 on the next cycle.
  - Required: no `ovf_trig`.
- **Enable gating:**
  - Stimulus: `cks`=1; drop `en` at `cnt`=10, hold 20 cycles, raise `en` again.
  - Required: `cnt` holds 10 while `en`=0, and `clk_in`=0 within 1 cycle of `en` falling.
  - Required: the first `clk_in` rise is 2 pclk after `en` rises, and the first increment to 11 happens in that cycle.
- **Clock-select sweep:** with `en`=1, measure the `clk_in` period for `cks` = 0..3 -> 2, 4, 8 and 16 pclk.
